// File: rtl/syn_harness_ser.sv
// -----------------------------------------------------------------------------
// syn_harness_ser
// Parallel-to-serial harness stage. Accepts a WIDTH-bit word over a
// valid/ready handshake and emits it one bit per clock on a single pin,
// framed by first/last markers, optionally followed by an even-parity bit.
// Keeps wide results observable through one I/O.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   word_in     parallel word to serialize (sampled only on a transfer)
//   word_valid  word_in is valid
//   word_ready  block can accept a word this cycle (combinational)
//   bit_out     serial data bit (registered)
//   bit_valid   bit_out carries a frame bit (registered)
//   bit_first   first beat of a frame (registered)
//   bit_last    last beat of a frame (registered)
//
// State | Meaning
// ------+---------------------------------------------
// IDLE  | no frame in progress, outputs held at 0
// DATA  | data beats being sent, cnt_q = beat index
// PAR   | parity beat being sent (only if PARITY_EN=1)
// -----------------------------------------------------------------------------
module syn_harness_ser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_first,
    output logic             bit_last
);

    localparam int FRAME_LEN = WIDTH + (PARITY_EN ? 1 : 0);
    localparam int CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_first_q, bit_first_d;
    logic             bit_last_q, bit_last_d;
    logic             alive_q;
    logic             xfer;
    logic             frame_end;

    // Bit of the shift register that goes on the wire next.
    function automatic logic head(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction

    // alive_q keeps word_ready low while in reset and until the first edge.
    assign word_ready = alive_q && ((state_q == IDLE) || (bit_valid_q && bit_last_q));
    assign xfer       = word_valid && word_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        bit_first_d = 1'b0;
        bit_last_d  = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            IDLE: ;
            DATA: begin
                if (cnt_q != CNT_LAST_DATA) begin
                    cnt_d       = cnt_q + 1'b1;
                    shift_d     = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    bit_out_d   = head(shift_d);
                    bit_valid_d = 1'b1;
                    bit_last_d  = (cnt_d == CNT_LAST);
                end else if (PARITY_EN) begin
                    state_d     = PAR;
                    cnt_d       = cnt_q + 1'b1;
                    bit_out_d   = par_q;
                    bit_valid_d = 1'b1;
                    bit_last_d  = 1'b1;
                end else begin
                    frame_end = 1'b1;
                end
            end
            PAR:     frame_end = 1'b1;
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // A transfer can only happen in IDLE or on the last beat, so it
        // always overrides the frame-end return to IDLE.
        if (xfer) begin
            state_d     = DATA;
            cnt_d       = '0;
            shift_d     = word_in;
            par_d       = ^word_in;
            bit_out_d   = head(word_in);
            bit_valid_d = 1'b1;
            bit_first_d = 1'b1;
            bit_last_d  = (FRAME_LEN == 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_first_q <= 1'b0;
            bit_last_q  <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_first_q <= bit_first_d;
            bit_last_q  <= bit_last_d;
            alive_q     <= 1'b1;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign bit_first = bit_first_q;
    assign bit_last  = bit_last_q;

endmodule

// File: tb/tb_syn_harness_ser.sv
// -----------------------------------------------------------------------------
// tb_syn_harness_ser
// Three instances: A (WIDTH=8, MSB first, parity), B (WIDTH=8, LSB first,
// no parity), C (WIDTH=1, no parity). Directed frame table, hand sequences
// for back-to-back / degenerate / mid-frame reset, then a random stream on A
// checked by a frame-reassembling scoreboard.
// -----------------------------------------------------------------------------
module tb_syn_harness_ser;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_word, b_word;
    logic [0:0] c_word;
    logic a_valid, a_ready, a_bit, a_bv, a_bf, a_bl;
    logic b_valid, b_ready, b_bit, b_bv, b_bf, b_bl;
    logic c_valid, c_ready, c_bit, c_bv, c_bf, c_bl;

    int total = 0;
    int bad   = 0;

    syn_harness_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .word_in(a_word), .word_valid(a_valid),
        .word_ready(a_ready), .bit_out(a_bit), .bit_valid(a_bv),
        .bit_first(a_bf), .bit_last(a_bl));

    syn_harness_ser #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_in(b_word), .word_valid(b_valid),
        .word_ready(b_ready), .bit_out(b_bit), .bit_valid(b_bv),
        .bit_first(b_bf), .bit_last(b_bl));

    syn_harness_ser #(.WIDTH(1), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .word_in(c_word), .word_valid(c_valid),
        .word_ready(c_ready), .bit_out(c_bit), .bit_valid(c_bv),
        .bit_first(c_bf), .bit_last(c_bl));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        int         dut;
        logic [7:0] word;
        int         len;
        logic [15:0] bits;   // beat k expected at bit k
        logic [15:0] first;
        logic [15:0] last;
        logic [15:0] ready;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {ready, bit, valid, first, last}
    function automatic logic [4:0] outs(input int d);
        case (d)
            0:       return {a_ready, a_bit, a_bv, a_bf, a_bl};
            1:       return {b_ready, b_bit, b_bv, b_bf, b_bl};
            default: return {c_ready, c_bit, c_bv, c_bf, c_bl};
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] w);
        case (d)
            0: begin a_valid = v; a_word = w; end
            1: begin b_valid = v; b_word = w; end
            default: begin c_valid = v; c_word = w[0]; end
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] o;
        drive(v.dut, 1'b1, v.word);
        step();
        drive(v.dut, 1'b0, 8'h00);
        for (int k = 0; k < v.len; k++) begin
            o = outs(v.dut);
            chk($sformatf("%s_bit%0d", v.name, k), o[3], v.bits[k]);
            chk($sformatf("%s_valid%0d", v.name, k), o[2], 1'b1);
            chk($sformatf("%s_first%0d", v.name, k), o[1], v.first[k]);
            chk($sformatf("%s_last%0d", v.name, k), o[0], v.last[k]);
            chk($sformatf("%s_ready%0d", v.name, k), o[4], v.ready[k]);
            step();
        end
        o = outs(v.dut);
        chk($sformatf("%s_idle", v.name), o[3:1], 3'b000);
    endtask

    // Random-phase scoreboard state
    logic [7:0] rq[$];
    bit         mon_en = 1'b0;
    int         frames = 0;
    int         flen   = 0;
    logic [8:0] fbits;

    // Reassemble frames of instance A purely from the framing rules.
    initial begin
        logic [7:0] rw;
        logic [7:0] expw;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (a_bv) begin
                    chk("rand_first", a_bf, flen == 0);
                    chk("rand_last", a_bl, flen == 8);
                    fbits[flen] = a_bit;
                    flen++;
                    if (flen == 9) begin
                        rw = '0;
                        for (int k = 0; k < 8; k++) rw = {rw[6:0], fbits[k]};
                        chk("rand_parity", ^fbits, 1'b0);
                        chk("rand_pending", rq.size() > 0, 1'b1);
                        if (rq.size() > 0) begin
                            expw = rq.pop_front();
                            chk("rand_word", rw, expw);
                        end
                        frames++;
                        flen = 0;
                    end
                end else begin
                    chk("rand_idle_bit", a_bit, 1'b0);
                    chk("rand_gap", flen, 0);
                end
            end
        end
    end

    initial begin
        vec_t       tbl[9];
        vec_t       v0f;
        logic [4:0] o;
        logic [2:0] cw;
        logic [7:0] w;
        int         sent;

        tbl[0] = '{"a_A5", 0, 8'hA5, 9, 16'h00A5, 16'h0001, 16'h0100, 16'h0100};
        tbl[1] = '{"a_0F", 0, 8'h0F, 9, 16'h00F0, 16'h0001, 16'h0100, 16'h0100};
        tbl[2] = '{"a_01", 0, 8'h01, 9, 16'h0180, 16'h0001, 16'h0100, 16'h0100};
        tbl[3] = '{"a_80", 0, 8'h80, 9, 16'h0101, 16'h0001, 16'h0100, 16'h0100};
        tbl[4] = '{"b_01", 1, 8'h01, 8, 16'h0001, 16'h0001, 16'h0080, 16'h0080};
        tbl[5] = '{"b_C3", 1, 8'hC3, 8, 16'h00C3, 16'h0001, 16'h0080, 16'h0080};
        tbl[6] = '{"b_80", 1, 8'h80, 8, 16'h0080, 16'h0001, 16'h0080, 16'h0080};
        tbl[7] = '{"c_1", 2, 8'h01, 1, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        tbl[8] = '{"c_0", 2, 8'h00, 1, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
        v0f    = '{"a_post_rst_0F", 0, 8'h0F, 9, 16'h00F0, 16'h0001, 16'h0100, 16'h0100};

        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);

        // Reset: everything low for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < 3; d++) chk($sformatf("rst_outs_d%0d", d), outs(d), 5'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                o = outs(d);
                chk($sformatf("post_rst_ready_d%0d", d), o[4], 1'b1);
                chk($sformatf("post_rst_valid_d%0d", d), o[3:0], 4'b0);
            end
        end

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back on B: 01 then 80, no gap
        drive(1, 1'b1, 8'h01);
        step();
        drive(1, 1'b1, 8'h80);
        for (int k = 0; k < 16; k++) begin
            o = outs(1);
            chk($sformatf("b2b_bit%0d", k), o[3], (k == 0) || (k == 15));
            chk($sformatf("b2b_valid%0d", k), o[2], 1'b1);
            chk($sformatf("b2b_first%0d", k), o[1], (k == 0) || (k == 8));
            chk($sformatf("b2b_last%0d", k), o[0], (k == 7) || (k == 15));
            chk($sformatf("b2b_ready%0d", k), o[4], (k == 7) || (k == 15));
            if (k == 8) drive(1, 1'b0, 8'h00);
            step();
        end
        o = outs(1);
        chk("b2b_idle", o[3:1], 3'b000);

        // Degenerate WIDTH=1 stream 1,0,1
        cw = 3'b101;
        drive(2, 1'b1, {7'b0, cw[0]});
        step();
        for (int k = 0; k < 3; k++) begin
            o = outs(2);
            chk($sformatf("w1_bit%0d", k), o[3], cw[k]);
            chk($sformatf("w1_marks%0d", k), o[2:0], 3'b111);
            chk($sformatf("w1_ready%0d", k), o[4], 1'b1);
            if (k < 2) drive(2, 1'b1, {7'b0, cw[k+1]});
            else drive(2, 1'b0, 8'h00);
            step();
        end
        o = outs(2);
        chk("w1_idle", o[3:1], 3'b000);
        chk("w1_idle_ready", o[4], 1'b1);

        // Mid-frame reset on A
        drive(0, 1'b1, 8'hFF);
        step();
        drive(0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            o = outs(0);
            chk($sformatf("mid_bit%0d", k), o[3:2], 2'b11);
            if (k < 3) step();
        end
        #3 rst_n = 1'b0;
        #1;
        chk("mid_async_clear", outs(0), 5'b0);
        step();
        chk("mid_held_clear", outs(0), 5'b0);
        rst_n = 1'b1;
        step();
        run_vec(v0f);

        // Random stream on A with valid gaps
        sent = 0;
        w = 8'($urandom);
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 30000 && sent < 1000; cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                drive(0, 1'b0, 8'($urandom));
            end else begin
                drive(0, 1'b1, w);
                if (a_ready) begin
                    rq.push_back(w);
                    sent++;
                    w = 8'($urandom);
                end
            end
            step();
        end
        drive(0, 1'b0, 8'h00);
        for (int i = 0; i < 40 && frames < sent; i++) step();
        step();
        mon_en = 1'b0;
        chk("rand_sent", sent, 1000);
        chk("rand_frames", frames, sent);
        chk("rand_queue_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
